// File: rtl/z_history_writer.sv
// Per-element read-modify-write of the z history: read the old z, then write it to z_prev
// and write the new element to z, one element at a time.
module z_history_writer #(
    parameter int INPUT_DIM  = 4,
    parameter int HORIZON    = 30,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           active_horizon,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] z_rdaddress,
    input  logic [DATA_WIDTH-1:0] z_data_out,
    output logic [ADDR_WIDTH-1:0] z_wraddress,
    output logic [DATA_WIDTH-1:0] z_wrdata,
    output logic                  z_wren,
    output logic [ADDR_WIDTH-1:0] z_prev_wraddress,
    output logic [DATA_WIDTH-1:0] z_prev_wrdata,
    output logic                  z_prev_wren,
    output logic [15:0]           elem_count,
    output logic                  done
);

    // state      | meaning
    // IDLE       | waiting for start, element count latched on start
    // ACCEPT     | in_ready high, waiting for an in_data handshake
    // WAIT       | RD_LAT cycles for the old z value to arrive
    // COMMIT     | one-cycle write strobe to both memories
    // DONE_STATE | done held until start drops
    typedef enum logic [2:0] {IDLE, ACCEPT, WAIT, COMMIT, DONE_STATE} state_t;

    state_t                  state;
    logic [15:0]             index;
    logic [15:0]             ne;
    logic [DATA_WIDTH-1:0]   in_latch;
    logic [2:0]              wait_cnt;
    logic [15:0]             h_eff;
    logic [15:0]             ne_start;

    always_comb begin
        h_eff    = (active_horizon > 32'(HORIZON)) ? 16'(HORIZON) : active_horizon[15:0];
        ne_start = (h_eff > 16'd1) ? (h_eff - 16'd1) * 16'(INPUT_DIM) : 16'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            index            <= '0;
            ne               <= '0;
            in_latch         <= '0;
            wait_cnt         <= '0;
            in_ready         <= 1'b0;
            z_rdaddress      <= '0;
            z_wraddress      <= '0;
            z_wrdata         <= '0;
            z_wren           <= 1'b0;
            z_prev_wraddress <= '0;
            z_prev_wrdata    <= '0;
            z_prev_wren      <= 1'b0;
            elem_count       <= '0;
            done             <= 1'b0;
        end else begin
            z_wren      <= 1'b0;
            z_prev_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        index      <= '0;
                        elem_count <= '0;
                        ne         <= ne_start;
                        if (ne_start != 16'd0) begin
                            state    <= ACCEPT;
                            in_ready <= 1'b1;
                        end else begin
                            state <= DONE_STATE;
                            done  <= 1'b1;
                        end
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        in_latch    <= in_data;
                        z_rdaddress <= index[ADDR_WIDTH-1:0];
                        wait_cnt    <= 3'(RD_LAT - 1);
                        in_ready    <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        // z_prev_wrdata doubles as the captured old_z register
                        z_prev_wrdata    <= z_data_out;
                        z_prev_wraddress <= index[ADDR_WIDTH-1:0];
                        z_prev_wren      <= 1'b1;
                        z_wrdata         <= in_latch;
                        z_wraddress      <= index[ADDR_WIDTH-1:0];
                        z_wren           <= 1'b1;
                        state            <= COMMIT;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                COMMIT: begin
                    elem_count <= elem_count + 16'd1;
                    index      <= index + 16'd1;
                    if ((index + 16'd1) < ne) begin
                        state    <= ACCEPT;
                        in_ready <= 1'b1;
                    end else begin
                        state <= DONE_STATE;
                        done  <= 1'b1;
                    end
                end
                DONE_STATE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z_history_writer.sv
// Directed and randomized passes against an array-based model of the z / z_prev memories.
module tb_z_history_writer;

    localparam int INPUT_DIM  = 4;
    localparam int HORIZON    = 30;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 9;
    localparam int RD_LAT     = 2;
    localparam int MEM_N      = 1 << ADDR_WIDTH;
    localparam int PIDX       = (RD_LAT > 1) ? RD_LAT - 2 : 0;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [31:0]           active_horizon;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] z_rdaddress;
    logic [DATA_WIDTH-1:0] z_data_out;
    logic [ADDR_WIDTH-1:0] z_wraddress;
    logic [DATA_WIDTH-1:0] z_wrdata;
    logic                  z_wren;
    logic [ADDR_WIDTH-1:0] z_prev_wraddress;
    logic [DATA_WIDTH-1:0] z_prev_wrdata;
    logic                  z_prev_wren;
    logic [15:0]           elem_count;
    logic                  done;

    int checks = 0;
    int failures = 0;

    logic [DATA_WIDTH-1:0] z_mem  [MEM_N];
    logic [DATA_WIDTH-1:0] zp_mem [MEM_N];
    logic [DATA_WIDTH-1:0] ref_z  [MEM_N];
    logic [DATA_WIDTH-1:0] ref_zp [MEM_N];
    logic [DATA_WIDTH-1:0] pipe   [4];

    always #5 clk = ~clk;

    z_history_writer #(
        .INPUT_DIM(INPUT_DIM), .HORIZON(HORIZON), .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .active_horizon(active_horizon),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .z_rdaddress(z_rdaddress), .z_data_out(z_data_out),
        .z_wraddress(z_wraddress), .z_wrdata(z_wrdata), .z_wren(z_wren),
        .z_prev_wraddress(z_prev_wraddress), .z_prev_wrdata(z_prev_wrdata),
        .z_prev_wren(z_prev_wren), .elem_count(elem_count), .done(done)
    );

    // Memory with RD_LAT cycles of read latency from the registered address
    always @(posedge clk) begin
        pipe[0] <= z_mem[z_rdaddress];
        for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
        if (z_wren) z_mem[z_wraddress] = z_wrdata;
        if (z_prev_wren) zp_mem[z_prev_wraddress] = z_prev_wrdata;
    end
    assign z_data_out = (RD_LAT == 1) ? z_mem[z_rdaddress] : pipe[PIDX];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_mem(input string tag);
        int bad = 0;
        for (int a = 0; a < MEM_N; a++)
            if (z_mem[a] !== ref_z[a] || zp_mem[a] !== ref_zp[a]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_wren"}, {z_wren, z_prev_wren}, 0);
        chk({tag, "_addr"}, {z_rdaddress, z_wraddress, z_prev_wraddress}, 0);
        chk({tag, "_wrdata"}, {z_wrdata, z_prev_wrdata}, 0);
        chk({tag, "_count"}, elem_count, 0);
    endtask

    // One pass: start at a negedge, drive in_valid with probability vpct%, check every commit.
    // seq selects in_data = 100+n; abort_after>0 pulses reset after that many commits.
    task automatic run_pass(input int h, input int vpct, input bit seq, input int abort_after);
        int heff, ne, ncommit, npush, last_c, done_cyc;
        bit saw_done;
        logic [DATA_WIDTH-1:0] q[$];
        logic [DATA_WIDTH-1:0] d;
        heff = (h > HORIZON) ? HORIZON : h;
        ne = (heff <= 1) ? 0 : (heff - 1) * INPUT_DIM;
        ncommit = 0; npush = 0; last_c = -1; done_cyc = -1; saw_done = 0;
        active_horizon = h;
        start = 1'b1;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 5000 && !saw_done; cyc++) begin
            @(negedge clk);
            if (cyc == 3) active_horizon = $urandom;
            chk("wren_pair", z_prev_wren, z_wren);
            if (z_wren) begin
                chk("commit_in_range", ncommit < ne, 1);
                chk("no_ready_in_commit", in_ready, 0);
                chk("q_nonempty", q.size() > 0, 1);
                d = (q.size() > 0) ? q.pop_front() : '0;
                chk("z_wraddress", z_wraddress, ncommit);
                chk("z_prev_wraddress", z_prev_wraddress, ncommit);
                chk("z_wrdata", z_wrdata, d);
                chk("z_prev_wrdata", z_prev_wrdata, ref_z[ncommit]);
                if (vpct == 100 && last_c >= 0) chk("commit_spacing", cyc - last_c, 2 + RD_LAT);
                last_c = cyc;
                ref_zp[ncommit] = ref_z[ncommit];
                ref_z[ncommit] = d;
                ncommit++;
                if (ncommit == abort_after) begin
                    @(negedge clk);
                    rst_n = 1'b0;
                    #1;
                    chk_zero("abort");
                    start = 1'b0;
                    in_valid = 1'b0;
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                    repeat (4) begin
                        @(negedge clk);
                        chk("idle_after_reset", {in_ready, z_wren, done}, 0);
                    end
                    chk_mem("abort_mem");
                    return;
                end
            end
            if (done) begin
                saw_done = 1;
                done_cyc = cyc;
            end else begin
                in_valid = ($urandom_range(0, 99) < vpct);
                in_data = seq ? DATA_WIDTH'(100 + npush) : DATA_WIDTH'($urandom);
                if (in_ready && in_valid) begin
                    q.push_back(in_data);
                    npush++;
                end
            end
        end
        chk("done_seen", saw_done, 1);
        if (ne == 0) chk("done_latency", done_cyc <= 1, 1);
        chk("commit_total", ncommit, ne);
        chk("elem_count", elem_count, ne);
        chk_mem("pass_mem");
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("done_hold", {done, in_ready, z_wren}, 3'b100);
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_drop", done, 0);
        @(negedge clk);
        chk("idle_ready", {in_ready, done, z_wren}, 0);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; start = 1'b0; active_horizon = '0; in_valid = 1'b0; in_data = '0;
        for (int a = 0; a < MEM_N; a++) begin
            z_mem[a] = DATA_WIDTH'(a); ref_z[a] = DATA_WIDTH'(a);
            zp_mem[a] = '1; ref_zp[a] = '1;
        end
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_pass(3, 100, 1'b1, 0);
        bad = 0;
        for (int n = 0; n < 8; n++)
            if (z_mem[n] !== DATA_WIDTH'(100 + n) || zp_mem[n] !== DATA_WIDTH'(n)) bad++;
        chk("scen_h3_contents", bad, 0);
        chk("scen_h3_untouched", {z_mem[8], zp_mem[8]}, {16'd8, 16'hffff});

        run_pass(1, 100, 1'b0, 0);
        run_pass(0, 100, 1'b0, 0);
        run_pass(40, 100, 1'b0, 0);
        chk("h40_last_addr", z_wraddress, 115);
        chk("h40_beyond", z_mem[116], 116);

        for (int a = 0; a < MEM_N; a++) begin
            z_mem[a] = DATA_WIDTH'($urandom); ref_z[a] = z_mem[a];
        end
        run_pass(5, 100, 1'b0, 3);
        run_pass(5, 70, 1'b0, 0);
        for (int r = 0; r < 6; r++) run_pass($urandom_range(0, 40), 60, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
